// File: rtl/minesweeper_board.sv
// minesweeper_board: game-state writer for an 8x8 (max) minesweeper board.
// It holds the bomb map, per-cell flags, revealed bits and adjacency counts,
// the cursor and the game status. The video scanner reads cells through the
// registered read port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   load, bomb_map[63:0]     start a new game with bit r*8+c = bomb at (r,c)
//   mv_up/down/left/right    cursor move pulses
//   reveal, flag             open / toggle flag on the cursor cell
//   rd_row, rd_col           read address
//   rd_cell[9:0]             {0, count[3:0], revealed, flag, bomb, covered, selected}
//   busy                     high while counting neighbours or flood-opening
//   game_lost, game_won      terminal status
//   revealed_cnt[6:0]        number of opened non-bomb cells
//
// Command inputs are single-cycle pulses with no handshake: a pulse seen
// outside PLAY is dropped, not queued.
module minesweeper_board #(
  parameter int FILAS    = 8,
  parameter int COLUMNAS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] bomb_map,
  input  logic        mv_up,
  input  logic        mv_down,
  input  logic        mv_left,
  input  logic        mv_right,
  input  logic        reveal,
  input  logic        flag,
  input  logic [2:0]  rd_row,
  input  logic [2:0]  rd_col,
  output logic [9:0]  rd_cell,
  output logic        busy,
  output logic        game_lost,
  output logic        game_won,
  output logic [6:0]  revealed_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_FLOOD = 3'd3;
  localparam logic [2:0] S_LOST  = 3'd4;
  localparam logic [2:0] S_WON   = 3'd5;

  localparam logic [6:0] CELLS  = 7'(FILAS * COLUMNAS);
  localparam logic [2:0] LAST_R = 3'(FILAS - 1);
  localparam logic [2:0] LAST_C = 3'(COLUMNAS - 1);

  logic [2:0] state;
  logic [2:0] cur_r, cur_c;
  logic [2:0] scan_r, scan_c;
  logic       opened_any;
  logic [6:0] bomb_total;

  logic       bomb_q [8][8];
  logic       flag_q [8][8];
  logic       rev_q  [8][8];
  logic       cov_q  [8][8];
  logic [3:0] cnt_q  [8][8];

  logic [9:0] rd_code;
  logic [3:0] scan_cnt;
  logic       scan_seed;
  logic [6:0] load_total;
  logic [2:0] next_r, next_c;
  logic       scan_last;
  logic       flood_open;
  logic [6:0] win_target;

  assign busy      = (state == S_COUNT) || (state == S_FLOOD);
  assign game_lost = (state == S_LOST);
  assign game_won  = (state == S_WON);

  assign scan_last  = (scan_r == LAST_R) && (scan_c == LAST_C);
  assign next_c     = (scan_c == LAST_C) ? 3'd0 : scan_c + 3'd1;
  assign next_r     = (scan_c == LAST_C) ? scan_r + 3'd1 : scan_r;
  assign win_target = CELLS - bomb_total;
  assign flood_open = cov_q[scan_r][scan_c] && !flag_q[scan_r][scan_c] &&
                      !bomb_q[scan_r][scan_c] && scan_seed;

  // Read port: selected bit comes from the live cursor, never stored.
  always_comb begin
    rd_code = '0;
    if (int'(rd_row) < FILAS && int'(rd_col) < COLUMNAS)
      rd_code = {1'b0, cnt_q[rd_row][rd_col], rev_q[rd_row][rd_col],
                 flag_q[rd_row][rd_col], bomb_q[rd_row][rd_col],
                 cov_q[rd_row][rd_col], (rd_row == cur_r) && (rd_col == cur_c)};
  end

  // Neighbourhood of the scan cell: bomb count (COUNT) and whether any
  // opened zero-count neighbour exists (FLOOD seed).
  always_comb begin
    scan_cnt  = '0;
    scan_seed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (i < FILAS && j < COLUMNAS &&
            i <= int'(scan_r) + 1 && i >= int'(scan_r) - 1 &&
            j <= int'(scan_c) + 1 && j >= int'(scan_c) - 1 &&
            !(i == int'(scan_r) && j == int'(scan_c))) begin
          if (bomb_q[3'(i)][3'(j)])
            scan_cnt = scan_cnt + 4'd1;
          if (rev_q[3'(i)][3'(j)] && !bomb_q[3'(i)][3'(j)] && cnt_q[3'(i)][3'(j)] == 4'd0)
            scan_seed = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_total = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i < FILAS && j < COLUMNAS && bomb_map[6'(i * 8 + j)])
          load_total = load_total + 7'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          cov_q[i][j]  <= 1'b1;
          bomb_q[i][j] <= 1'b0;
          flag_q[i][j] <= 1'b0;
          rev_q[i][j]  <= 1'b0;
          cnt_q[i][j]  <= '0;
        end
      end
      state        <= S_IDLE;
      cur_r        <= '0;
      cur_c        <= '0;
      scan_r       <= '0;
      scan_c       <= '0;
      opened_any   <= 1'b0;
      bomb_total   <= '0;
      revealed_cnt <= '0;
      rd_cell      <= '0;
    end else begin
      rd_cell <= rd_code;
      if (load) begin
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < 8; j++) begin
            cov_q[i][j]  <= 1'b1;
            flag_q[i][j] <= 1'b0;
            rev_q[i][j]  <= 1'b0;
            cnt_q[i][j]  <= '0;
            bomb_q[i][j] <= (i < FILAS && j < COLUMNAS) ? bomb_map[6'(i * 8 + j)] : 1'b0;
          end
        end
        bomb_total   <= load_total;
        cur_r        <= '0;
        cur_c        <= '0;
        revealed_cnt <= '0;
        scan_r       <= '0;
        scan_c       <= '0;
        opened_any   <= 1'b0;
        state        <= S_COUNT;
      end else begin
        case (state)
          S_COUNT: begin
            cnt_q[scan_r][scan_c] <= scan_cnt;
            scan_r <= scan_last ? 3'd0 : next_r;
            scan_c <= scan_last ? 3'd0 : next_c;
            if (scan_last)
              state <= S_PLAY;
          end
          S_PLAY: begin
            if (reveal) begin
              if (!flag_q[cur_r][cur_c] && !rev_q[cur_r][cur_c]) begin
                if (bomb_q[cur_r][cur_c]) begin
                  // Show every bomb at once.
                  for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < 8; j++) begin
                      if (bomb_q[i][j]) begin
                        cov_q[i][j] <= 1'b0;
                        rev_q[i][j] <= 1'b1;
                      end
                    end
                  end
                  state <= S_LOST;
                end else begin
                  cov_q[cur_r][cur_c] <= 1'b0;
                  rev_q[cur_r][cur_c] <= 1'b1;
                  revealed_cnt        <= revealed_cnt + 7'd1;
                  if (cnt_q[cur_r][cur_c] == 4'd0) begin
                    scan_r     <= '0;
                    scan_c     <= '0;
                    opened_any <= 1'b0;
                    state      <= S_FLOOD;
                  end else if (revealed_cnt + 7'd1 == win_target) begin
                    state <= S_WON;
                  end
                end
              end
            end else if (flag) begin
              if (cov_q[cur_r][cur_c])
                flag_q[cur_r][cur_c] <= !flag_q[cur_r][cur_c];
            end else if (mv_up) begin
              if (cur_r != 3'd0) cur_r <= cur_r - 3'd1;
            end else if (mv_down) begin
              if (cur_r != LAST_R) cur_r <= cur_r + 3'd1;
            end else if (mv_left) begin
              if (cur_c != 3'd0) cur_c <= cur_c - 3'd1;
            end else if (mv_right) begin
              if (cur_c != LAST_C) cur_c <= cur_c + 3'd1;
            end
          end
          S_FLOOD: begin
            // Openings land in the arrays next cycle, so a cell opened
            // earlier in this pass already seeds later cells of the pass.
            if (flood_open) begin
              cov_q[scan_r][scan_c] <= 1'b0;
              rev_q[scan_r][scan_c] <= 1'b1;
              revealed_cnt          <= revealed_cnt + 7'd1;
            end
            if (scan_last) begin
              scan_r     <= '0;
              scan_c     <= '0;
              opened_any <= 1'b0;
              if (!(opened_any || flood_open))
                state <= (revealed_cnt == win_target) ? S_WON : S_PLAY;
            end else begin
              scan_r     <= next_r;
              scan_c     <= next_c;
              opened_any <= opened_any || flood_open;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
